// File: rtl/core_mem_arbiter_if.sv
// rtl/core_mem_arbiter_if.sv - core fetch/data port and external memory port signals of core_mem_arbiter
// slave is the arbiter side, master is the core/memory side driving the arbiter.
interface core_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    fetch_request_enable;
  logic                    freq_mode;
  logic [ADDR_WIDTH-1:0]   freq_addr;
  logic [DATA_WIDTH-1:0]   freq_wdata;
  logic [DATA_WIDTH/8-1:0] freq_wstrb;
  logic                    fetch_response_enable;
  logic [DATA_WIDTH-1:0]   fresp_data;
  logic                    mem_request_enable;
  logic                    mreq_mode;
  logic [ADDR_WIDTH-1:0]   mreq_addr;
  logic [DATA_WIDTH-1:0]   mreq_wdata;
  logic [DATA_WIDTH/8-1:0] mreq_wstrb;
  logic                    mem_response_enable;
  logic [DATA_WIDTH-1:0]   mresp_data;
  logic                    ext_req_valid;
  logic                    ext_req_ready;
  logic                    ext_mode;
  logic [ADDR_WIDTH-1:0]   ext_addr;
  logic [DATA_WIDTH-1:0]   ext_wdata;
  logic [DATA_WIDTH/8-1:0] ext_wstrb;
  logic                    ext_resp_valid;
  logic [DATA_WIDTH-1:0]   ext_resp_data;
  logic                    busy;
  logic                    proto_err;

  modport slave (
    input  fetch_request_enable, freq_mode, freq_addr, freq_wdata, freq_wstrb,
    input  mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb,
    input  ext_req_ready, ext_resp_valid, ext_resp_data,
    output fetch_response_enable, fresp_data, mem_response_enable, mresp_data,
    output ext_req_valid, ext_mode, ext_addr, ext_wdata, ext_wstrb, busy, proto_err
  );

  modport master (
    output fetch_request_enable, freq_mode, freq_addr, freq_wdata, freq_wstrb,
    output mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb,
    output ext_req_ready, ext_resp_valid, ext_resp_data,
    input  fetch_response_enable, fresp_data, mem_response_enable, mresp_data,
    input  ext_req_valid, ext_mode, ext_addr, ext_wdata, ext_wstrb, busy, proto_err
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - latches fetch/data request pulses and serialises them onto one valid/ready memory port
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default build is fixed priority, mem over fetch.
module core_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  core_mem_arbiter_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SLOT_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state, state_next;
  logic                   owner, owner_next;  // 1 = mem port, 0 = fetch port
  logic                   fetch_full, mem_full;
  logic [SLOT_WIDTH-1:0]  fetch_slot, mem_slot, owner_slot;
  logic [DATA_WIDTH-1:0]  fresp_q, mresp_q;
  logic                   proto_err_q, grant_mem, issue, release_slot, fetch_resp, mem_resp;

  // A slot being serviced stays full until its response is captured, so a pulse then is a protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_full  <= 1'b0;
      mem_full    <= 1'b0;
      fetch_slot  <= '0;
      mem_slot    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (release_slot && !owner) fetch_full <= 1'b0;
      if (release_slot && owner)  mem_full   <= 1'b0;
      if (bus.fetch_request_enable) begin
        if (fetch_full) begin
          proto_err_q <= 1'b1;
        end else begin
          fetch_full <= 1'b1;
          fetch_slot <= {bus.freq_mode, bus.freq_addr, bus.freq_wdata, bus.freq_wstrb};
        end
      end
      if (bus.mem_request_enable) begin
        if (mem_full) begin
          proto_err_q <= 1'b1;
        end else begin
          mem_full <= 1'b1;
          mem_slot <= {bus.mreq_mode, bus.mreq_addr, bus.mreq_wdata, bus.mreq_wstrb};
        end
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    last_owner <= 1'b0;
    else if (state == IDLE && (fetch_full || mem_full)) last_owner <= grant_mem;
  end

  assign grant_mem = mem_full && (!fetch_full || !last_owner);
`else
  assign grant_mem = mem_full;
`endif

  always_comb begin
    state_next   = state;
    owner_next   = owner;
    issue        = 1'b0;
    release_slot = 1'b0;
    fetch_resp   = 1'b0;
    mem_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_full || mem_full) begin
          owner_next = grant_mem;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (bus.ext_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (bus.ext_resp_valid) begin
          release_slot = 1'b1;
          state_next   = RESP;
        end
      end
      RESP: begin
        fetch_resp = !owner;
        mem_resp   = owner;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      fresp_q <= '0;
      mresp_q <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      if (release_slot && !owner) fresp_q <= bus.ext_resp_data;
      if (release_slot && owner)  mresp_q <= bus.ext_resp_data;
    end
  end

  assign owner_slot = owner ? mem_slot : fetch_slot;
  assign {bus.ext_mode, bus.ext_addr, bus.ext_wdata, bus.ext_wstrb} = issue ? owner_slot : '0;
  assign bus.ext_req_valid         = issue;
  assign bus.fetch_response_enable = fetch_resp;
  assign bus.mem_response_enable   = mem_resp;
  assign bus.fresp_data            = fresp_q;
  assign bus.mresp_data            = mresp_q;
  assign bus.busy                  = (state != IDLE);
  assign bus.proto_err             = proto_err_q;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - self-checking bench for core_mem_arbiter: vector table, directed corners, random vs model
module tb_core_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic SM = 1'b0;  // second tie goes to fetch
`else
  localparam logic SM = 1'b1;  // second tie goes to mem
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  core_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic fp; logic [31:0] faddr;
    logic mp; logic mmode; logic [31:0] maddr; logic [31:0] mwdata;
    logic rdy; logic rv; logic [31:0] rdata;
    logic e_valid; logic e_mode; logic [31:0] e_addr; logic [31:0] e_wdata; logic [3:0] e_wstrb;
    logic e_fr; logic e_mr; logic [31:0] e_rdata; logic e_busy;
  } vec_t;
  vec_t tv[20];

  logic pend[2], issued[2], exp_resp[2], pmode[2];
  logic [31:0] paddr[2], pwdata[2];
  logic [3:0] pwstrb[2];
  logic inflight, fp, mp;
  int ip;
  logic [31:0] exp_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.fetch_request_enable = 0; bus.freq_mode = 0; bus.freq_addr = 0; bus.freq_wdata = 0; bus.freq_wstrb = 0;
    bus.mem_request_enable = 0; bus.mreq_mode = 0; bus.mreq_addr = 0; bus.mreq_wdata = 0; bus.mreq_wstrb = 0;
    bus.ext_req_ready = 0; bus.ext_resp_valid = 0; bus.ext_resp_data = 0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.ext_req_valid && n < 20) begin
      step();
      n++;
    end
    chk(name, bus.ext_req_valid, 1);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_fresp"}, bus.fetch_response_enable, 0);
    chk({name, "_mresp"}, bus.mem_response_enable, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{H,32'h0,   H,H,32'h2000,32'h12345678, L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,L};
    tv[1]  = '{L,32'h0,   L,L,32'h0,32'h0,           L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,L};
    tv[2]  = '{L,32'h0,   L,L,32'h0,32'h0,           H,L,32'h0,        H,H,32'h2000,32'h12345678,4'hF,               L,L,32'h0,H};
    tv[3]  = '{L,32'h0,   L,L,32'h0,32'h0,           L,H,32'hAAAA0001, L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,H};
    tv[4]  = '{L,32'h0,   H,L,32'h3000,32'h0,        L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         L,H,32'hAAAA0001,H};
    tv[5]  = '{L,32'h0,   L,L,32'h0,32'h0,           L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,L};
    tv[6]  = '{L,32'h0,   L,L,32'h0,32'h0,           H,L,32'h0,        H,L,(SM ? 32'h3000 : 32'h0),32'h0,(SM ? 4'hF : 4'h0), L,L,32'h0,H};
    tv[7]  = '{L,32'h0,   L,L,32'h0,32'h0,           L,H,32'h1111,     L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,H};
    tv[8]  = '{L,32'h0,   L,L,32'h0,32'h0,           L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         ~SM,SM,32'h1111,H};
    tv[9]  = '{L,32'h0,   L,L,32'h0,32'h0,           L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,L};
    tv[10] = '{L,32'h0,   L,L,32'h0,32'h0,           H,L,32'h0,        H,L,(SM ? 32'h0 : 32'h3000),32'h0,(SM ? 4'h0 : 4'hF), L,L,32'h0,H};
    tv[11] = '{L,32'h0,   L,L,32'h0,32'h0,           L,H,32'h2222,     L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,H};
    tv[12] = '{L,32'h0,   L,L,32'h0,32'h0,           L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         SM,~SM,32'h2222,H};
    tv[13] = '{L,32'h0,   L,L,32'h0,32'h0,           L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,L};
    tv[14] = '{H,32'h100, L,L,32'h0,32'h0,           L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,L};
    tv[15] = '{L,32'h0,   L,L,32'h0,32'h0,           L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,L};
    tv[16] = '{L,32'h0,   L,L,32'h0,32'h0,           H,L,32'h0,        H,L,32'h100,32'h0,4'h0,                       L,L,32'h0,H};
    tv[17] = '{L,32'h0,   L,L,32'h0,32'h0,           L,H,32'hDEADBEEF, L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,H};
    tv[18] = '{L,32'h0,   L,L,32'h0,32'h0,           L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         H,L,32'hDEADBEEF,H};
    tv[19] = '{L,32'h0,   L,L,32'h0,32'h0,           L,L,32'h0,        L,L,32'h0,32'h0,4'h0,                         L,L,32'h0,L};

    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("reset_valid", bus.ext_req_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk_quiet("reset");
    chk("reset_fresp_data", bus.fresp_data, 0);
    chk("reset_mresp_data", bus.mresp_data, 0);
    chk("reset_proto_err", bus.proto_err, 0);
    chk("reset_ext_addr", bus.ext_addr, 0);
    step();
    rst = 1'b0;

    // Ties, same-cycle reload on mem response, then a single fetch read with minimum latency.
    for (int i = 0; i < 20; i++) begin
      bus.fetch_request_enable = tv[i].fp; bus.freq_addr = tv[i].faddr;
      bus.freq_mode = 0; bus.freq_wdata = 0; bus.freq_wstrb = 0;
      bus.mem_request_enable = tv[i].mp; bus.mreq_mode = tv[i].mmode; bus.mreq_addr = tv[i].maddr;
      bus.mreq_wdata = tv[i].mwdata; bus.mreq_wstrb = tv[i].mp ? 4'hF : 4'h0;
      bus.ext_req_ready = tv[i].rdy; bus.ext_resp_valid = tv[i].rv; bus.ext_resp_data = tv[i].rdata;
      #1;
      chk($sformatf("row%0d_valid", i), bus.ext_req_valid, tv[i].e_valid);
      chk($sformatf("row%0d_busy", i), bus.busy, tv[i].e_busy);
      chk($sformatf("row%0d_fresp", i), bus.fetch_response_enable, tv[i].e_fr);
      chk($sformatf("row%0d_mresp", i), bus.mem_response_enable, tv[i].e_mr);
      if (tv[i].e_valid) begin
        chk($sformatf("row%0d_mode", i), bus.ext_mode, tv[i].e_mode);
        chk($sformatf("row%0d_addr", i), bus.ext_addr, tv[i].e_addr);
        chk($sformatf("row%0d_wdata", i), bus.ext_wdata, tv[i].e_wdata);
        chk($sformatf("row%0d_wstrb", i), bus.ext_wstrb, tv[i].e_wstrb);
      end
      if (tv[i].e_fr) chk($sformatf("row%0d_fdata", i), bus.fresp_data, tv[i].e_rdata);
      if (tv[i].e_mr) chk($sformatf("row%0d_mdata", i), bus.mresp_data, tv[i].e_rdata);
      step();
    end
    idle_inputs();
    chk("table_proto_err", bus.proto_err, 0);

    // ready held low for 5 cycles in ISSUE
    bus.mem_request_enable = 1; bus.mreq_mode = 1; bus.mreq_addr = 32'h44;
    bus.mreq_wdata = 32'hCAFEF00D; bus.mreq_wstrb = 4'h5;
    step();
    idle_inputs();
    wait_valid("stall_issue");
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", bus.ext_req_valid, 1);
      chk("stall_mode", bus.ext_mode, 1);
      chk("stall_addr", bus.ext_addr, 32'h44);
      chk("stall_wdata", bus.ext_wdata, 32'hCAFEF00D);
      chk("stall_wstrb", bus.ext_wstrb, 4'h5);
      chk_quiet("stall");
      step();
    end
    bus.ext_req_ready = 1;
    step();
    bus.ext_req_ready = 0;
    bus.ext_resp_valid = 1; bus.ext_resp_data = 32'h77;
    chk_quiet("stall_wait");
    step();
    bus.ext_resp_valid = 0;
    chk("stall_mresp", bus.mem_response_enable, 1);
    chk("stall_fresp", bus.fetch_response_enable, 0);
    chk("stall_mdata", bus.mresp_data, 32'h77);
    step();
    chk("stall_mresp_one_cycle", bus.mem_response_enable, 0);

    // second fetch pulse while fetch slot pending
    bus.fetch_request_enable = 1; bus.freq_addr = 32'h200;
    step();
    bus.freq_addr = 32'h300;
    step();
    idle_inputs();
    chk("dup_proto_err", bus.proto_err, 1);
    wait_valid("dup_issue");
    chk("dup_addr", bus.ext_addr, 32'h200);
    bus.ext_req_ready = 1;
    step();
    bus.ext_req_ready = 0; bus.ext_resp_valid = 1; bus.ext_resp_data = 32'h99;
    step();
    bus.ext_resp_valid = 0;
    chk("dup_fresp", bus.fetch_response_enable, 1);
    chk("dup_fdata", bus.fresp_data, 32'h99);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("dup_no_reissue", bus.ext_req_valid, 0);
      chk_quiet("dup_after");
    end
    chk("dup_proto_err_sticky", bus.proto_err, 1);

    // reset while waiting for the response
    bus.fetch_request_enable = 1; bus.freq_addr = 32'h400;
    step();
    idle_inputs();
    wait_valid("rstw_issue");
    bus.ext_req_ready = 1;
    step();
    bus.ext_req_ready = 0;
    chk("rstw_busy_before", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_busy", bus.busy, 0);
    chk("rstw_proto_err", bus.proto_err, 0);
    chk("rstw_fresp_data", bus.fresp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.ext_resp_valid = 1; bus.ext_resp_data = 32'h55;
    step();
    bus.ext_resp_valid = 0;
    for (int k = 0; k < 4; k++) begin
      chk_quiet("rstw_after");
      chk("rstw_after_busy", bus.busy, 0);
      chk("rstw_after_valid", bus.ext_req_valid, 0);
      chk("rstw_after_fdata", bus.fresp_data, 0);
      step();
    end

    // random traffic against a transaction-level model; the bench plays the external memory
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; issued[p] = 0; exp_resp[p] = 0;
    end
    inflight = 0; ip = 0; exp_data = 0;
    for (int c = 0; c < 3400; c++) begin
      chk("rnd_fresp", bus.fetch_response_enable, exp_resp[0]);
      chk("rnd_mresp", bus.mem_response_enable, exp_resp[1]);
      if (exp_resp[0]) chk("rnd_fdata", bus.fresp_data, exp_data);
      if (exp_resp[1]) chk("rnd_mdata", bus.mresp_data, exp_data);
      exp_resp[0] = 0; exp_resp[1] = 0;
      fp = (c < 3000) && !pend[0] && ($urandom_range(0, 3) == 0);
      mp = (c < 3000) && !pend[1] && ($urandom_range(0, 3) == 0);
      bus.ext_resp_valid = 0;
      if (inflight) begin
        if ($urandom_range(0, 2) == 0) begin
          exp_data = $urandom;
          bus.ext_resp_valid = 1; bus.ext_resp_data = exp_data;
          exp_resp[ip] = 1; pend[ip] = 0; issued[ip] = 0; inflight = 0;
        end
      end else if ($urandom_range(0, 4) == 0) begin
        bus.ext_resp_valid = 1; bus.ext_resp_data = $urandom;
      end
      bus.ext_req_ready = 1'($urandom_range(0, 1));
      if (bus.ext_req_valid && bus.ext_req_ready) begin
        ip = int'(bus.ext_addr[31]);
        chk("rnd_owner_pending", pend[ip] && !issued[ip], 1);
        chk("rnd_mode", bus.ext_mode, pmode[ip]);
        chk("rnd_addr", bus.ext_addr, paddr[ip]);
        chk("rnd_wdata", bus.ext_wdata, pwdata[ip]);
        chk("rnd_wstrb", bus.ext_wstrb, pwstrb[ip]);
        issued[ip] = 1; inflight = 1;
      end
      bus.fetch_request_enable = fp;
      if (fp) begin
        pend[0] = 1; pmode[0] = 1'($urandom_range(0, 1)); paddr[0] = $urandom & 32'h7FFFFFFF;
        pwdata[0] = $urandom; pwstrb[0] = 4'($urandom);
        bus.freq_mode = pmode[0]; bus.freq_addr = paddr[0]; bus.freq_wdata = pwdata[0]; bus.freq_wstrb = pwstrb[0];
      end
      bus.mem_request_enable = mp;
      if (mp) begin
        pend[1] = 1; pmode[1] = 1'($urandom_range(0, 1)); paddr[1] = $urandom | 32'h80000000;
        pwdata[1] = $urandom; pwstrb[1] = 4'($urandom);
        bus.mreq_mode = pmode[1]; bus.mreq_addr = paddr[1]; bus.mreq_wdata = pwdata[1]; bus.mreq_wstrb = pwstrb[1];
      end
      step();
    end
    chk("rnd_drained", pend[0] | pend[1] | inflight, 0);
    chk("rnd_proto_err", bus.proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Sits directly downstream of the core's two memory ports (instruction fetch and data access).
- Latches each port's single-cycle request pulse and arbitrates between the two ports.
- Issues one transaction at a time on a shared valid/ready external memory port.
- Routes the external response back to the owning port as a one-cycle response pulse.

Parameters:
ADDR_WIDTH, 32, width of addresses on all ports
DATA_WIDTH, 32, width of data on all ports; strobe width is DATA_WIDTH/8

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
fetch_request_enable  input  1  one-cycle fetch request pulse
freq_mode  input  1  1=write, 0=read; sampled with the pulse
freq_addr  input  ADDR_WIDTH  fetch address
freq_wdata  input  DATA_WIDTH  fetch write data
freq_wstrb  input  DATA_WIDTH/8  fetch byte strobes
fetch_response_enable  output  1  one-cycle fetch response pulse
fresp_data  output  DATA_WIDTH  fetch read data, valid with the pulse
mem_request_enable  input  1  one-cycle data request pulse
mreq_mode  input  1  1=write, 0=read
mreq_addr  input  ADDR_WIDTH  data address
mreq_wdata  input  DATA_WIDTH  data write data
mreq_wstrb  input  DATA_WIDTH/8  data byte strobes
mem_response_enable  output  1  one-cycle data response pulse
mresp_data  output  DATA_WIDTH  data read data, valid with the pulse
ext_req_valid  output  1  external request valid
ext_req_ready  input  1  external request accepted
ext_mode  output  1  external request mode (1=write)
ext_addr  output  ADDR_WIDTH  external address
ext_wdata  output  DATA_WIDTH  external write data
ext_wstrb  output  DATA_WIDTH/8  external byte strobes
ext_resp_valid  input  1  external response (reads and write acks)
ext_resp_data  input  DATA_WIDTH  external read data
busy  output  1  state is not IDLE
proto_err  output  1  sticky: a request pulse arrived while the same port was already pending

Behaviour:
- Reset: all outputs 0; state IDLE; both pending slots empty; proto_err cleared. Reset mid-transaction drops all pending and in-flight work and generates no response.
- Pending slots, one per port, hold {mode, addr, wdata, wstrb}.
  - A request pulse loads its slot on that edge.
  - A pulse on a port whose slot is already full (including the slot being serviced) is dropped and sets proto_err.
  - A pulse arriving in the same cycle as that port's response pulse is legal and is loaded.
- State machine:
  - IDLE: if any slot is full, select the owner by arbitration, register it, and go to ISSUE. Otherwise stay.
  - ISSUE: ext_req_valid=1, with ext_mode/addr/wdata/wstrb taken from the owner's slot and held stable. On ext_req_ready=1, go to WAIT.
  - WAIT: on ext_resp_valid=1, capture ext_resp_data, clear the owner's slot, and go to RESP.
  - RESP: drive the owner's response_enable=1 for exactly one cycle with captured data on fresp_data/mresp_data; go to IDLE.
- ext_resp_valid outside WAIT is ignored.
- Write requests also complete with a response pulse; the returned data is whatever ext_resp_data carried.
- fresp_data/mresp_data hold their last value between pulses.
- Minimum latency, request pulse edge to response pulse: 4 cycles (ready and resp_valid each asserted on first opportunity).
- At most one external transaction is outstanding. Only the owner's slot is locked; the other port may load its slot at any time.
- Arbitration when both slots are full in IDLE: mem port wins (fixed priority), unless the optional feature below is enabled.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both slots are full in IDLE, grant the port that did not own the previous transaction. The last-owner register resets to fetch, so mem wins the first tie.
- Undefined: fixed priority, mem over fetch; no last-owner register exists.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Fetch read, addr 0x100: ready and resp_valid (data 0xDEADBEEF) on first opportunity -> ext_addr=0x100, ext_mode=0; fetch_response_enable one cycle, 4 cycles after the pulse, fresp_data=0xDEADBEEF; mem_response_enable stays 0.
- Same-cycle fetch (0x0) and mem write (0x2000, wdata 0x12345678, wstrb 0xF) -> mem issued first, then fetch. With ARB_ROUND_ROBIN_EN, a second tie grants fetch first.
- ext_req_ready held low 5 cycles in ISSUE -> ext_req_valid and all ext payload fields stable throughout; no response until accepted and answered.
- Second fetch pulse while the fetch slot is pending -> dropped, proto_err=1 and sticky; the first request completes normally.
- rst asserted in WAIT, then ext_resp_valid pulsed after release -> no response pulse, busy=0, all outputs 0.
- Mem pulse in the same cycle as mem_response_enable -> new request accepted and served; no proto_err.
